dma_rd_arbiter: RTL and testbench

- Shares the single host-memory DMA read channel between NUM_REQ requesters, e.g. several decompressor io_control instances.
- Arbitrates burst requests round-robin and forwards the winning address and length to the DMA engine.
- Records each granted requester in an in-order tag FIFO.
- Steers returned read beats, and their taken handshake, back to the requester owning the oldest outstanding burst.
- Sits between the io_control read ports and the top-level dma_rd_* ports.

---
 rtl/dma_rd_arbiter_if.sv | 51 +++++
 rtl/dma_rd_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_dma_rd_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_rd_arbiter_if.sv
// Bus interfaces for dma_rd_arbiter.
//   dma_rd_req_if : requester side (io_control read ports).
//     master = requesters (drive req_*, rsp_taken), slave = arbiter.
//   dma_rd_dma_if : DMA engine side (top-level dma_rd_* ports).
//     master = arbiter (drives request, data_taken), slave = DMA engine.
interface dma_rd_req_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 512
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*8-1:0]      req_len;
  logic [NUM_REQ-1:0]        req_ack;
  logic [DATA_W-1:0]         rsp_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic                      rsp_last;
  logic [NUM_REQ-1:0]        rsp_taken;

  modport master (
    output req_valid, req_addr, req_len, rsp_taken,
    input  req_ack, rsp_data, rsp_valid, rsp_last
  );
  modport slave (
    input  req_valid, req_addr, req_len, rsp_taken,
    output req_ack, rsp_data, rsp_valid, rsp_last
  );
endinterface

interface dma_rd_dma_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 512
);
  logic              dma_rd_req;
  logic [ADDR_W-1:0] dma_rd_addr;
  logic [7:0]        dma_rd_len;
  logic              dma_rd_req_ack;
  logic [DATA_W-1:0] dma_rd_data;
  logic              dma_rd_data_valid;
  logic              dma_rd_data_last;
  logic              dma_rd_data_taken;

  modport master (
    output dma_rd_req, dma_rd_addr, dma_rd_len, dma_rd_data_taken,
    input  dma_rd_req_ack, dma_rd_data, dma_rd_data_valid, dma_rd_data_last
  );
  modport slave (
    input  dma_rd_req, dma_rd_addr, dma_rd_len, dma_rd_data_taken,
    output dma_rd_req_ack, dma_rd_data, dma_rd_data_valid, dma_rd_data_last
  );
endinterface

// File: rtl/dma_rd_arbiter.sv
// dma_rd_arbiter: shares one DMA read channel between NUM_REQ requesters.
// Round-robin arbitration of burst requests, in-order tag FIFO of granted
// requesters, and zero-latency steering of returned beats to the owner of
// the oldest outstanding burst.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req_bus    : dma_rd_req_if.slave  (req_valid/addr/len/ack, rsp_*)
//   dma_bus    : dma_rd_dma_if.master (dma_rd_req/addr/len/ack, dma_rd_data*)
//   busy       : request in flight to the DMA engine or any burst outstanding
// Optional (macro DMA_RD_ARB_STATS_EN):
//   grant_count  : per-requester saturating count of accepted bursts (16b each)
//   stall_cycles : saturating count of cycles a request waits on a full FIFO
module dma_rd_arbiter #(
  parameter int unsigned NUM_REQ            = 4,
  parameter int unsigned REQ_ID_W           = 2,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
  parameter int unsigned MAX_OUTSTANDING    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  dma_rd_req_if.slave         req_bus,
  dma_rd_dma_if.master        dma_bus,
  output logic                busy
`ifdef DMA_RD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] grant_count,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW    = C_M_AXI_DATA_WIDTH;
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_ARB = 1'b0,
    ST_REQ = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [REQ_ID_W-1:0]   r_ptr;
  logic [REQ_ID_W-1:0]   r_gnt_id;
  logic [AW-1:0]         r_addr;
  logic [7:0]            r_len;

  logic [REQ_ID_W-1:0]   r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_pick_vld;
  logic [REQ_ID_W-1:0]   w_pick_id;
  logic                  w_grant;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full;
  logic [REQ_ID_W-1:0]   w_head;
  logic [NUM_REQ-1:0]    w_head_oh;
  logic                  w_taken;
  logic [DW-1:0]         w_beat_data;

  // Index of the candidate 'off' positions above 'base', wrapping at NUM_REQ.
  function automatic logic [REQ_ID_W-1:0] rr_idx(input logic [REQ_ID_W-1:0] base,
                                                 input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return REQ_ID_W'(s);
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_head  = r_fifo[r_rd_ptr];

  // Round-robin pick: first requester above the last served one.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_id  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!w_pick_vld && req_bus.req_valid[rr_idx(r_ptr, i)]) begin
        w_pick_vld = 1'b1;
        w_pick_id  = rr_idx(r_ptr, i);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (!w_full && w_pick_vld) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dma_bus.dma_rd_req_ack) begin
          w_push      = 1'b1;
          w_state_nxt = ST_ARB;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ARB;
    else        r_state <= w_state_nxt;
  end

  // Granted request: captured at grant, held until the DMA engine acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_id <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_ptr    <= '0;
    end else begin
      if (w_grant) begin
        r_gnt_id <= w_pick_id;
        r_addr   <= req_bus.req_addr[32'(w_pick_id)*AW +: AW];
        r_len    <= req_bus.req_len[32'(w_pick_id)*8 +: 8];
      end
      if (w_push) r_ptr <= r_gnt_id;
    end
  end

  // In-order tag FIFO of requesters owning outstanding bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= r_gnt_id;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Beat steering: only the head-of-FIFO owner sees valid; empty FIFO stalls.
  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_head_oh[k] = !w_empty && (w_head == REQ_ID_W'(k));
    end
  end

  assign w_taken     = |(w_head_oh & req_bus.rsp_taken);
  assign w_pop       = dma_bus.dma_rd_data_valid && dma_bus.dma_rd_data_last && w_taken;
  assign w_beat_data = dma_bus.dma_rd_data;

  assign req_bus.rsp_data  = w_beat_data;
  assign req_bus.rsp_last  = dma_bus.dma_rd_data_last;
  assign req_bus.rsp_valid = w_head_oh & {NUM_REQ{dma_bus.dma_rd_data_valid}};

  // Ack pulse goes out in the DMA ack cycle so the requester drops its
  // request before the next arbitration.
  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_bus.req_ack[k] = w_push && (r_gnt_id == REQ_ID_W'(k));
    end
  end

  assign dma_bus.dma_rd_req        = (r_state == ST_REQ);
  assign dma_bus.dma_rd_addr       = r_addr;
  assign dma_bus.dma_rd_len        = r_len;
  assign dma_bus.dma_rd_data_taken = w_taken;

  assign busy = (r_state != ST_ARB) || !w_empty;

`ifdef DMA_RD_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] r_grant_cnt;
  logic [31:0]              r_stall_cnt;

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (req_bus.req_ack[k] && (r_grant_cnt[k] != 16'hFFFF)) begin
          r_grant_cnt[k] <= r_grant_cnt[k] + 16'd1;
        end
      end
      if ((|req_bus.req_valid) && w_full && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign grant_count  = r_grant_cnt;
  assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Self-checking bench for dma_rd_arbiter: behavioural model (queue of
// outstanding owners, round-robin pointer, in-flight request) compared every
// cycle, plus directed scenarios with literal expectations.
module tb_dma_rd_arbiter;
  localparam int N    = 4;
  localparam int AW   = 64;
  localparam int DW   = 512;
  localparam int MAXO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
`ifdef DMA_RD_ARB_STATS_EN
  logic [N*16-1:0] grant_count;
  logic [31:0]     stall_cycles;
`endif

  dma_rd_req_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) rq_if ();
  dma_rd_dma_if #(.ADDR_W(AW), .DATA_W(DW))              dm_if ();

  dma_rd_arbiter #(
    .NUM_REQ(N), .REQ_ID_W(2), .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_bus(rq_if.slave), .dma_bus(dm_if.master), .busy(busy)
`ifdef DMA_RD_ARB_STATS_EN
    , .grant_count(grant_count), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- stimulus state ----------------
  logic [N-1:0] rq_v;
  logic [AW-1:0] rq_a [N];
  logic [7:0]    rq_l [N];
  bit  rq_auto = 0;
  int  rq_pct = 0;
  int  ack_mode = 2;       // 0 random, 1 immediate, 2 never, 3 after 3 cycles
  int  ack_cnt = 0;
  int  data_budget = 0;    // bursts the DMA engine may still return
  bit  data_always = 0;
  bit  stray = 0;
  bit  taken_block = 0;
  int  taken_pct = 100;
  int  dq [$];             // lengths of bursts accepted by the DMA engine
  int  beat = 0;
  int  cyc = 0;
  int  total_acks = 0;
  int  ack_per [N];
  int  beats_to [N];
  int  glog [$];
  int  gcyc [$];
  int  n_pushpop = 0;

  // Observations latched at negedge for the driver.
  bit           n_accept = 0;
  int           n_len = 0;
  bit           n_beat = 0;
  logic [N-1:0] n_ack = '0;
  logic [N-1:0] n_rv = '0;

  always_comb begin
    rq_if.req_valid = rq_v;
    for (int k = 0; k < N; k++) begin
      rq_if.req_addr[k*AW +: AW] = rq_a[k];
      rq_if.req_len[k*8 +: 8]    = rq_l[k];
    end
  end

  task automatic new_req(input int k);
    rq_v[k] = 1'b1;
    rq_a[k] = {$urandom, $urandom};
    rq_l[k] = 8'($urandom_range(0, 5));
  endtask

  // ---------------- requesters + DMA engine driver ----------------
  always @(posedge clk) begin
    bit a;
    bit dv;
    #1;
    cyc++;
    if (n_accept) begin
      dq.push_back(n_len);
      ack_cnt = 0;
    end
    if (n_beat && dq.size() > 0) begin
      for (int k = 0; k < N; k++) if (n_rv[k]) beats_to[k]++;
      if (beat == dq[0]) begin
        void'(dq.pop_front());
        beat = 0;
        if (data_budget > 0) data_budget--;
      end else beat++;
    end
    for (int k = 0; k < N; k++) begin
      if (n_ack[k]) begin
        glog.push_back(k);
        gcyc.push_back(cyc);
        total_acks++;
        ack_per[k]++;
        if (rq_auto && $urandom_range(99) < 32'(rq_pct)) new_req(k);
        else rq_v[k] = 1'b0;
      end else if (!rq_v[k] && rq_auto && $urandom_range(99) < 32'(rq_pct)) new_req(k);
    end
    a = 1'b0;
    if (dm_if.dma_rd_req) begin
      case (ack_mode)
        0:       a = ($urandom_range(2) == 0);
        1:       a = 1'b1;
        3:       a = (ack_cnt >= 3);
        default: a = 1'b0;
      endcase
      ack_cnt++;
    end
    dm_if.dma_rd_req_ack = a;
    dv = 1'b0;
    dm_if.dma_rd_data_last = 1'b0;
    if (stray) begin
      dv = 1'b1;
      dm_if.dma_rd_data_last = 1'($urandom_range(1));
    end else if (dq.size() > 0 && data_budget > 0 && (data_always || $urandom_range(1) == 1)) begin
      dv = 1'b1;
      dm_if.dma_rd_data_last = (beat == dq[0]);
    end
    dm_if.dma_rd_data_valid = dv;
    for (int w = 0; w < DW/32; w++) dm_if.dma_rd_data[w*32 +: 32] = $urandom;
    for (int k = 0; k < N; k++)
      rq_if.rsp_taken[k] = !taken_block && ($urandom_range(99) < 32'(taken_pct));
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  bit            m_iss;
  int            m_gid, m_ptr;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_len;
  int            mq [$];

  always @(negedge clk) begin
    logic [N-1:0] e_ack, e_rv;
    bit e_tk, nz, pop, push;
    int hd;
    if (!rst_n) begin
      m_iss = 0; m_gid = 0; m_ptr = 0; m_addr = '0; m_len = '0;
      mq.delete();
    end
    nz = (mq.size() > 0);
    hd = nz ? mq[0] : 0;
    e_ack = '0;
    if (m_iss && dm_if.dma_rd_req_ack) e_ack[m_gid] = 1'b1;
    e_rv = '0;
    if (nz && dm_if.dma_rd_data_valid) e_rv[hd] = 1'b1;
    e_tk = nz && rq_if.rsp_taken[hd];
    chk("dma_rd_req", 64'(dm_if.dma_rd_req), 64'(m_iss));
    if (m_iss) begin
      chk("dma_rd_addr", dm_if.dma_rd_addr, m_addr);
      chk("dma_rd_len", 64'(dm_if.dma_rd_len), 64'(m_len));
    end
    chk("req_ack", 64'(rq_if.req_ack), 64'(e_ack));
    chk("rsp_valid", 64'(rq_if.rsp_valid), 64'(e_rv));
    chk("dma_rd_data_taken", 64'(dm_if.dma_rd_data_taken), 64'(e_tk));
    chk("rsp_last", 64'(rq_if.rsp_last), 64'(dm_if.dma_rd_data_last));
    chk("busy", 64'(busy), 64'(m_iss || nz));
    n_checks++;
    if (rq_if.rsp_data !== dm_if.dma_rd_data) begin
      n_fail++;
      $display("FAIL rsp_data: got low 0x%0h expected low 0x%0h", rq_if.rsp_data[63:0], dm_if.dma_rd_data[63:0]);
    end
    n_accept = rst_n && dm_if.dma_rd_req && dm_if.dma_rd_req_ack;
    n_len    = int'(dm_if.dma_rd_len);
    n_beat   = rst_n && dm_if.dma_rd_data_valid && dm_if.dma_rd_data_taken;
    n_ack    = rst_n ? rq_if.req_ack : '0;
    n_rv     = rq_if.rsp_valid;
    if (rst_n) begin
      pop = e_tk && dm_if.dma_rd_data_valid && dm_if.dma_rd_data_last;
      push = 0;
      if (m_iss) begin
        if (dm_if.dma_rd_req_ack) begin
          push = 1; m_ptr = m_gid; m_iss = 0;
        end
      end else if (mq.size() < MAXO) begin
        for (int i = 1; i <= N; i++) begin
          int c;
          c = (m_ptr + i) % N;
          if (rq_if.req_valid[c]) begin
            m_iss = 1; m_gid = c;
            m_addr = rq_if.req_addr[c*AW +: AW];
            m_len  = rq_if.req_len[c*8 +: 8];
            break;
          end
        end
      end
      if (push && pop) n_pushpop++;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(m_gid);
    end
  end

  task automatic sync();
    @(posedge clk); #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int t, base;
    int a1, b1;
    int exp_ord [8];
    rq_v = '0;
    for (int k = 0; k < N; k++) begin rq_a[k] = '0; rq_l[k] = '0; ack_per[k] = 0; beats_to[k] = 0; end
    dm_if.dma_rd_req_ack = 1'b0; dm_if.dma_rd_data_valid = 1'b0;
    dm_if.dma_rd_data_last = 1'b0; dm_if.dma_rd_data = '0;
    rq_if.rsp_taken = '0;
    exp_ord = '{1, 2, 3, 0, 1, 2, 3, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dma_rd_req", 64'(dm_if.dma_rd_req), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_req_ack", 64'(rq_if.req_ack), 64'd0);
    chk("reset_rsp_valid", 64'(rq_if.rsp_valid), 64'd0);
    chk("reset_addr", dm_if.dma_rd_addr, 64'd0);
    chk("reset_len", 64'(dm_if.dma_rd_len), 64'd0);
    sync(); rst_n = 1'b1;

    // All requesting, immediate acks, no data: order and 8-deep limit.
    data_budget = 0; ack_mode = 1; rq_pct = 100; rq_auto = 1;
    base = glog.size();
    for (t = 0; t < 100 && total_acks < base + 8; t++) @(negedge clk);
    chk("eight_grants_timeout", 64'(t < 100), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk("grant_order", 64'(glog[base+i]), 64'(exp_ord[i]));
      if (i > 0) chk("grant_spacing", 64'(gcyc[base+i] - gcyc[base+i-1]), 64'd2);
    end
    repeat (10) begin
      @(negedge clk);
      chk("full_no_dma_req", 64'(dm_if.dma_rd_req), 64'd0);
    end
    chk("full_busy", 64'(busy), 64'd1);
    chk("full_ack_count", 64'(total_acks - base), 64'd8);
    sync(); data_budget = 1; data_always = 1; taken_pct = 100;
    for (t = 0; t < 100 && total_acks < base + 9; t++) @(negedge clk);
    chk("ninth_grant_timeout", 64'(t < 100), 64'd1);
    if (glog.size() > base + 8) chk("ninth_grant_id", 64'(glog[base+8]), 64'd1);

    sync(); rq_auto = 0; data_budget = 1000; data_always = 0; taken_pct = 70;
    for (t = 0; t < 3000 && (busy || rq_v != '0); t++) @(negedge clk);
    chk("drain1_timeout", 64'(t < 3000), 64'd1);

    // Single request with delayed ack and backpressure.
    sync();
    ack_mode = 3; taken_block = 1; data_always = 1; data_budget = 1;
    a1 = ack_per[1]; b1 = beats_to[1];
    rq_v[1] = 1'b1; rq_a[1] = 64'h1000; rq_l[1] = 8'd7;
    for (t = 0; t < 10 && !dm_if.dma_rd_req; t++) @(negedge clk);
    chk("single_req_timeout", 64'(t < 10), 64'd1);
    repeat (3) begin
      chk("single_req_held", 64'(dm_if.dma_rd_req), 64'd1);
      chk("single_addr", dm_if.dma_rd_addr, 64'h1000);
      chk("single_len", 64'(dm_if.dma_rd_len), 64'd7);
      @(negedge clk);
    end
    for (t = 0; t < 20 && !dm_if.dma_rd_data_valid; t++) @(negedge clk);
    chk("single_data_timeout", 64'(t < 20), 64'd1);
    repeat (5) begin
      chk("bp_taken", 64'(dm_if.dma_rd_data_taken), 64'd0);
      chk("bp_rsp_valid", 64'(rq_if.rsp_valid), 64'b0010);
      @(negedge clk);
    end
    sync(); taken_block = 0; taken_pct = 100;
    for (t = 0; t < 50 && busy; t++) @(negedge clk);
    chk("single_done_timeout", 64'(t < 50), 64'd1);
    chk("single_ack_pulses", 64'(ack_per[1] - a1), 64'd1);
    chk("single_beats", 64'(beats_to[1] - b1), 64'd8);

    // Beat with nothing outstanding stays stalled.
    sync(); stray = 1; sync();
    repeat (4) begin
      @(negedge clk);
      chk("stray_rsp_valid", 64'(rq_if.rsp_valid), 64'd0);
      chk("stray_taken", 64'(dm_if.dma_rd_data_taken), 64'd0);
    end
    sync(); stray = 0;

    // Random traffic.
    rq_auto = 1; rq_pct = 30; ack_mode = 0; data_budget = 1_000_000;
    data_always = 0; taken_pct = 70;
    repeat (3000) @(negedge clk);
    sync(); rq_auto = 0;
    for (t = 0; t < 3000 && (busy || rq_v != '0); t++) @(negedge clk);
    chk("drain2_timeout", 64'(t < 3000), 64'd1);

    // Reset while a request is in flight with two bursts outstanding.
    sync(); ack_mode = 1; data_budget = 0;
    base = total_acks;
    rq_v[0] = 1'b1; rq_a[0] = 64'h2000; rq_l[0] = 8'd3;
    rq_v[3] = 1'b1; rq_a[3] = 64'h3000; rq_l[3] = 8'd1;
    for (t = 0; t < 20 && total_acks < base + 2; t++) @(negedge clk);
    chk("pre_reset_acks_timeout", 64'(t < 20), 64'd1);
    sync(); ack_mode = 2;
    rq_v[2] = 1'b1; rq_a[2] = 64'hABC0; rq_l[2] = 8'd2;
    for (t = 0; t < 20 && !dm_if.dma_rd_req; t++) @(negedge clk);
    chk("pre_reset_req_timeout", 64'(t < 20), 64'd1);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dma_req", 64'(dm_if.dma_rd_req), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_req_ack", 64'(rq_if.req_ack), 64'd0);
    chk("async_rst_addr", dm_if.dma_rd_addr, 64'd0);
    rq_v = '0; ack_mode = 1; data_budget = 100;
    repeat (2) @(posedge clk);
    #2;
    dq.delete(); beat = 0;
    rst_n = 1'b1;
    sync();
    base = glog.size();
    rq_v[2] = 1'b1; rq_a[2] = 64'h4000; rq_l[2] = 8'd4;
    for (t = 0; t < 20 && glog.size() <= base; t++) @(negedge clk);
    chk("post_reset_grant_timeout", 64'(t < 20), 64'd1);
    if (glog.size() > base) chk("post_reset_grant_id", 64'(glog[base]), 64'd2);
    for (t = 0; t < 200 && busy; t++) @(negedge clk);
    chk("post_reset_drain_timeout", 64'(t < 200), 64'd1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
